// File: rtl/matrix_operand_sequencer.sv
// Front end for the matrix accelerator: latches a command, streams in the a/b operands,
// runs the accelerator until done (or watchdog expiry) and returns the captured result.
module matrix_operand_sequencer #(
    parameter int unsigned WORD_W  = 264,
    parameter int unsigned A_ROWS  = 16,
    parameter int unsigned TIMEOUT = 1024,
    parameter int unsigned TO_W    = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_int8,
    input  logic                     cmd_int4,
    input  logic                     cmd_vsq,
    input  logic                     cmd_ppu_en,
    input  logic [7:0]               cmd_scale,
    input  logic [7:0]               cmd_bias,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WORD_W-1:0]        in_data,
    input  logic                     abort,
    output logic [A_ROWS*WORD_W-1:0] a_vec,
    output logic [WORD_W-1:0]        b_vec,
    output logic                     is_int8_mode,
    output logic                     is_int4_mode,
    output logic                     is_vsq,
    output logic [7:0]               scale,
    output logic [7:0]               bias,
    output logic                     valid_mac,
    output logic                     valid_ppu,
    input  logic                     done_wire,
    input  logic [127:0]             softmax_out,
    input  logic [135:0]             quantized_data,
    input  logic [15:0]              vec_max,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [127:0]             res_softmax,
    output logic [135:0]             res_quant,
    output logic [15:0]              res_max,
    output logic                     res_timeout,
    output logic                     cfg_err
);

    localparam int unsigned CW = (A_ROWS > 1) ? $clog2(A_ROWS) : 1;

    typedef enum logic [2:0] {StIdle, StLoadA, StLoadB, StRun, StResult} state_e;

    state_e          state_q;
    logic [CW-1:0]   beat_q;
    logic [TO_W-1:0] to_cnt_q;
    logic            ppu_en_q;

    logic cmd_fire;
    logic beat_fire;
    logic res_fire;

    // cmd_ready/in_ready are only ever high in their own states, so the handshakes
    // alone are enough to qualify acceptance.
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign beat_fire = in_valid && in_ready;
    assign res_fire  = res_valid && res_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            beat_q       <= '0;
            to_cnt_q     <= '0;
            ppu_en_q     <= 1'b0;
            cmd_ready    <= 1'b0;
            in_ready     <= 1'b0;
            a_vec        <= '0;
            b_vec        <= '0;
            is_int8_mode <= 1'b0;
            is_int4_mode <= 1'b0;
            is_vsq       <= 1'b0;
            scale        <= '0;
            bias         <= '0;
            valid_mac    <= 1'b0;
            valid_ppu    <= 1'b0;
            res_valid    <= 1'b0;
            res_softmax  <= '0;
            res_quant    <= '0;
            res_max      <= '0;
            res_timeout  <= 1'b0;
            cfg_err      <= 1'b0;
        end else if (abort && state_q != StIdle) begin
            // Operands, results and cfg_err are deliberately left untouched.
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
            in_ready  <= 1'b0;
            valid_mac <= 1'b0;
            valid_ppu <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    cmd_ready <= 1'b1;
                    if (cmd_fire) begin
                        // int8 wins a conflicting mode request; the conflict is remembered.
                        is_int8_mode <= cmd_int8;
                        is_int4_mode <= cmd_int4 & ~cmd_int8;
                        is_vsq       <= cmd_vsq;
                        scale        <= cmd_scale;
                        bias         <= cmd_bias;
                        ppu_en_q     <= cmd_ppu_en;
                        cfg_err      <= cfg_err | (cmd_int8 & cmd_int4);
                        beat_q       <= '0;
                        cmd_ready    <= 1'b0;
                        in_ready     <= 1'b1;
                        state_q      <= StLoadA;
                    end
                end
                StLoadA: begin
                    if (beat_fire) begin
                        a_vec[int'(beat_q)*WORD_W +: WORD_W] <= in_data;
                        beat_q <= beat_q + CW'(1);
                        if (beat_q == CW'(A_ROWS - 1)) begin
                            state_q <= StLoadB;
                        end
                    end
                end
                StLoadB: begin
                    if (beat_fire) begin
                        b_vec     <= in_data;
                        in_ready  <= 1'b0;
                        valid_mac <= 1'b1;
                        valid_ppu <= ppu_en_q;
                        to_cnt_q  <= '0;
                        state_q   <= StRun;
                    end
                end
                StRun: begin
                    if (done_wire) begin
                        res_softmax <= softmax_out;
                        res_quant   <= quantized_data;
                        res_max     <= vec_max;
                        res_timeout <= 1'b0;
                        res_valid   <= 1'b1;
                        valid_mac   <= 1'b0;
                        valid_ppu   <= 1'b0;
                        state_q     <= StResult;
                    end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        res_softmax <= '0;
                        res_quant   <= '0;
                        res_max     <= '0;
                        res_timeout <= 1'b1;
                        res_valid   <= 1'b1;
                        valid_mac   <= 1'b0;
                        valid_ppu   <= 1'b0;
                        state_q     <= StResult;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end
                StResult: begin
                    if (res_fire) begin
                        res_valid <= 1'b0;
                        cmd_ready <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
